// File: rtl/tbus_pkg.sv
// Shared trinity-bus definitions: operation codes, arbiter FSM states and
// transaction owner.
package tbus_pkg;

  localparam logic [1:0] TBUS_READ  = 2'b01;
  localparam logic [1:0] TBUS_WRITE = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StReq   = 2'b01,
    StWait  = 2'b10,
    StDrain = 2'b11
  } arb_state_e;

  // Owner value doubles as the requester index into rr_arb2.
  typedef enum logic {
    OWNER_LD = 1'b0,
    OWNER_ST = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On contention the requester not granted last
// time wins; the last-grant record is updated on every enabled grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // Resets to requester 1 so the first contended grant goes to requester 0.
  logic last_q, last_d;

  always_comb begin
    gnt_o    = 2'b00;
    last_d   = last_q;
    if (en_i) begin
      gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
      gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);
      if (|gnt_o) begin
        last_d = gnt_o[1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dcache_arb.sv
// Serializes load reads and committed-store writes onto one dcache tbus port,
// one transaction at a time, and discards completions of flushed loads.
module dcache_arb
  import tbus_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ld_index_valid,
  output logic              ld_index_ready,
  input  logic [ADDR_W-1:0] ld_index,
  output logic [DATA_W-1:0] ld_read_data,
  output logic              ld_operation_done,
  input  logic              ld_flush_valid,
  input  logic              st_index_valid,
  output logic              st_index_ready,
  input  logic [ADDR_W-1:0] st_index,
  input  logic [DATA_W-1:0] st_write_data,
  input  logic [DATA_W-1:0] st_write_mask,
  output logic              st_operation_done,
  output logic              dc_index_valid,
  input  logic              dc_index_ready,
  output logic [ADDR_W-1:0] dc_index,
  output logic [DATA_W-1:0] dc_write_data,
  output logic [DATA_W-1:0] dc_write_mask,
  output logic [1:0]        dc_operation_type,
  input  logic [DATA_W-1:0] dc_read_data,
  input  logic              dc_operation_done
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wmask_q, wmask_d;
  logic [1:0]        optype_q, optype_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       is_idle;
  logic       ld_kill;

  assign is_idle = (state_q == StIdle);

  // A flushing load is not offered to the arbiter, so any grant is a fire.
  assign req = {st_index_valid, ld_index_valid & ~ld_flush_valid};

  rr_arb2 u_rr_arb2 (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .en_i   (is_idle),
    .req_i  (req),
    .gnt_o  (gnt)
  );

  assign ld_index_ready = is_idle & gnt[0] & ~ld_flush_valid;
  assign st_index_ready = is_idle & gnt[1];

  assign ld_kill = ld_flush_valid & (owner_q == OWNER_LD);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    index_d  = index_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    optype_d = optype_q;
    unique case (state_q)
      StIdle: begin
        if (gnt[0]) begin
          state_d  = StReq;
          owner_d  = OWNER_LD;
          index_d  = ld_index;
          wdata_d  = '0;
          wmask_d  = '0;
          optype_d = TBUS_READ;
        end else if (gnt[1]) begin
          state_d  = StReq;
          owner_d  = OWNER_ST;
          index_d  = st_index;
          wdata_d  = st_write_data;
          wmask_d  = st_write_mask;
          optype_d = TBUS_WRITE;
        end
      end
      StReq: begin
        if (dc_index_ready) begin
          state_d = ld_kill ? StDrain : StWait;
        end else if (ld_kill) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (dc_operation_done) begin
          state_d = StIdle;
        end else if (ld_kill) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (dc_operation_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      owner_q  <= OWNER_LD;
      index_q  <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      optype_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      index_q  <= index_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      optype_q <= optype_d;
    end
  end

  assign dc_index_valid    = (state_q == StReq);
  assign dc_index          = index_q;
  // Load requests register zero data/mask, so no owner gating is needed here.
  assign dc_write_data     = wdata_q;
  assign dc_write_mask     = wmask_q;
  assign dc_operation_type = optype_q;

  assign ld_read_data      = dc_read_data;
  assign ld_operation_done = dc_operation_done & (state_q == StWait) &
                             (owner_q == OWNER_LD) & ~ld_flush_valid;
  assign st_operation_done = dc_operation_done & (state_q == StWait) &
                             (owner_q == OWNER_ST);

endmodule

// File: doc/dcache_arb.md
# dcache_arb

Two-client arbiter between the memory-block execution units and the data cache's trinity bus (tbus). It accepts load reads from the load unit and committed-store writes from the store queue and serializes them onto a single dcache tbus port, one transaction outstanding at a time. It routes read data and completion back to the owning client. On a load-side flush it drops the load's pending request, or swallows its completion, so a killed load never completes toward the load unit.

## Interface
Parameters:
- ADDR_W, 64, tbus index width
- DATA_W, 64, tbus data width (write mask is DATA_W bits)

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- ld_index_valid  in  1  load read request
- ld_index_ready  out  1  load request accepted this cycle
- ld_index  in  ADDR_W  load address
- ld_read_data  out  DATA_W  read data to load unit
- ld_operation_done  out  1  load transaction complete
- ld_flush_valid  in  1  kill the load transaction in flight
- st_index_valid  in  1  store write request
- st_index_ready  out  1  store request accepted
- st_index  in  ADDR_W  store address
- st_write_data  in  DATA_W  store data
- st_write_mask  in  DATA_W  store bit mask
- st_operation_done  out  1  store transaction complete
- dc_index_valid  out  1  request to dcache
- dc_index_ready  in  1  dcache accepts request
- dc_index  out  ADDR_W  address to dcache
- dc_write_data  out  DATA_W  write data to dcache
- dc_write_mask  out  DATA_W  write mask to dcache
- dc_operation_type  out  2  TBUS_READ or TBUS_WRITE
- dc_read_data  in  DATA_W  dcache read data
- dc_operation_done  in  1  dcache transaction complete

## Operation
- FSM states:
  - IDLE: accept one client.
  - REQ: request registered, dc_index_valid=1, held stable until dc_index_ready.
  - WAIT: accepted by dcache, waiting for dc_operation_done.
  - DRAIN: a killed load is outstanding; its completion is discarded.
- Arbitration in IDLE:
  - Only one requester valid: that client is granted.
  - Both valid: the client not granted last time wins.
  - last_grant is 1 bit, updated on every grant.
  - ld_index_ready and st_index_ready are combinational: IDLE & grant.
  - ld_index_ready is additionally gated by ~ld_flush_valid.
- On grant, register index/data/mask/type and owner, then go to REQ.
  - Load: type TBUS_READ, data and mask 0.
  - Store: type TBUS_WRITE.
- REQ → WAIT on dc_index_valid & dc_index_ready.
- WAIT → IDLE on dc_operation_done.
  - Owner load: ld_operation_done = 1.
  - Owner store: st_operation_done = 1.
- ld_read_data is a combinational passthrough of dc_read_data. It is meaningful only while ld_operation_done=1.
- dc_write_data and dc_write_mask are 0 whenever the owner is load.
- Flush, with load as owner:
  - REQ without dcache fire: → IDLE, no dcache access is made.
  - REQ with fire in the same cycle: → DRAIN.
  - WAIT without done: → DRAIN.
  - WAIT with done in the same cycle: ld_operation_done suppressed, → IDLE.
  - DRAIN: dc_operation_done produces no client done, → IDLE.
- Flush with store as owner is ignored. Committed stores are never killed.
- ld_operation_done = dc_operation_done & WAIT & owner==load & ~ld_flush_valid.

## Timing
- Reset values:
  - State IDLE, last_grant = store, so the first contended grant goes to load.
  - All registered request fields 0.
  - dc_index_valid, both ready outputs and both done outputs are 0.
- Client fire in cycle N → dc_index_valid in cycle N+1.
- Earliest completion: dcache ready in N+1 and done in N+2 gives client done in N+2, combinational from dc_operation_done.
- After a done in cycle M, the next client grant is no earlier than M+1, since IDLE is re-entered at M+1.
- dc_index, dc_write_data, dc_write_mask and dc_operation_type are stable for every cycle of REQ.
- dc_operation_done outside WAIT/DRAIN is ignored.
- Asynchronous reset mid-transaction returns to IDLE immediately. An outstanding dcache operation is the dcache's responsibility.

## Structure
- Shared package `tbus_pkg`:
  - TBUS_READ = 2'b01, TBUS_WRITE = 2'b10
  - the 2-bit state encoding
  - owner enum (OWNER_LD, OWNER_ST)
- Natural sub-module `rr_arb2`: 2-input round-robin grant with a last_grant register, enabled in IDLE.
- The FSM and request registers stay in the top.

## Test plan
- Single load to 0x1000, dcache ready at once, done 3 cycles later with data 0xDEAD_BEEF → ld_operation_done pulses once with ld_read_data 0xDEAD_BEEF, dc_operation_type TBUS_READ.
- Load and store valid in the same cycle after reset → load granted first; store granted on the first cycle back in IDLE; st_operation_done follows its dcache done; dc_write_mask matches st_write_mask.
- dc_index_ready held low 5 cycles → dc_index and dc_index_valid stable all 5 cycles; neither ready output asserts during that time.
- ld_flush_valid in REQ before dcache ready → next state IDLE, dc_index_valid never fires, no ld_operation_done.
- ld_flush_valid in WAIT, then dc_operation_done 2 cycles later → no ld_operation_done. A new load issued next is served normally and returns its own data.
- ld_flush_valid during a store transaction → store completes, st_operation_done=1, state sequence unchanged.
